// File: rtl/wb_seq_master_if.sv
// Wishbone classic-cycle bus between wb_seq_master and a slave.
// Signal names are from the master's point of view.
interface wb_seq_master_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr_o;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic                    cyc_o;
    logic                    stb_o;
    logic [SELECT_WIDTH-1:0] sel_o;
    logic                    we_o;
    logic                    ack_i;

    modport master (
        output adr_o, dat_o, cyc_o, stb_o, sel_o, we_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  adr_o, dat_o, cyc_o, stb_o, sel_o, we_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/wb_seq_master.sv
// Wishbone classic master: one command becomes a burst of single-beat transfers.
// Optional ack timeout is enabled by defining WB_SEQ_MASTER_TIMEOUT_EN.
module wb_seq_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    cmd_v_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic                    cmd_we_i,
    input  logic [SELECT_WIDTH-1:0] cmd_sel_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,

    input  logic                    wdata_v_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    wdata_yumi_o,

    output logic                    rdata_v_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    rdata_last_o,
    input  logic                    rdata_ready_i,

    output logic                    err_o,

    wb_seq_master_if.master         wb
);

    if (DATA_WIDTH % 8 != 0 || SELECT_WIDTH != DATA_WIDTH / 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("wb_seq_master: invalid parameter set");
    end

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(SELECT_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADR_STEP   = ADDR_WIDTH'(SELECT_WIDTH);

    typedef enum logic [1:0] {IDLE, FETCH, BUS, RESP} state_e;

    state_e                  r_state;
    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic [SELECT_WIDTH-1:0] r_sel;
    logic                    r_we;
    logic                    r_cyc;
    logic                    r_stb;
    logic [LEN_WIDTH-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_rdata_v;
    logic                    r_rdata_last;
    logic                    w_last;
    logic                    w_timeout;

    assign w_last = (r_cnt == '0);

`ifdef WB_SEQ_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    // Every path out of BUS passes through a non-BUS cycle, so this clears on each entry.
    always_ff @(posedge clk) begin
        if (!reset_n || r_state != BUS) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_timeout = (r_state == BUS) && !wb.ack_i && (r_tmo == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_we         <= 1'b0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_rdata_v    <= 1'b0;
            r_rdata_last <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_v_i) begin
                        r_adr <= cmd_addr_i & ALIGN_MASK;
                        r_sel <= cmd_sel_i;
                        r_we  <= cmd_we_i;
                        r_cnt <= cmd_len_i;
                        r_cyc <= 1'b1;
                        if (cmd_we_i) begin
                            r_state <= FETCH;
                        end else begin
                            r_stb   <= 1'b1;
                            r_state <= BUS;
                        end
                    end
                end

                FETCH: begin
                    if (wdata_v_i) begin
                        r_dat   <= wdata_i;
                        r_stb   <= 1'b1;
                        r_state <= BUS;
                    end
                end

                BUS: begin
                    if (wb.ack_i) begin
                        r_adr <= r_adr + ADR_STEP;
                        r_cnt <= r_cnt - 1'b1;
                        r_stb <= 1'b0;
                        if (!r_we) begin
                            // The last-beat flag is captured here because the counter moves on ack.
                            r_rdata      <= wb.dat_i;
                            r_rdata_v    <= 1'b1;
                            r_rdata_last <= w_last;
                            r_state      <= RESP;
                        end else if (w_last) begin
                            r_cyc   <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= FETCH;
                        end
                    end else if (w_timeout) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                RESP: begin
                    if (rdata_ready_i) begin
                        r_rdata_v    <= 1'b0;
                        r_rdata_last <= 1'b0;
                        if (r_rdata_last) begin
                            r_cyc   <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_stb   <= 1'b1;
                            r_state <= BUS;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = (r_state == IDLE);
    assign wdata_yumi_o = (r_state == FETCH) && wdata_v_i;

    assign rdata_v_o    = r_rdata_v;
    assign rdata_o      = r_rdata;
    assign rdata_last_o = r_rdata_last;

    assign wb.adr_o = r_adr;
    assign wb.dat_o = r_dat;
    assign wb.cyc_o = r_cyc;
    assign wb.stb_o = r_stb;
    assign wb.sel_o = r_sel;
    assign wb.we_o  = r_we;

endmodule

// File: tb/tb_wb_seq_master.sv
// Directed bench for wb_seq_master against a registered-ack RAM slave model.
// The timeout scenario is exercised only when WB_SEQ_MASTER_TIMEOUT_EN is defined.
module tb_wb_seq_master;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int SW  = 4;
    localparam int LW  = 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_v = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_we = 1'b0;
    logic [SW-1:0] cmd_sel = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wdata_v = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wdata_yumi;
    logic          rdata_v;
    logic [DW-1:0] rdata;
    logic          rdata_last;
    logic          rdata_ready = 1'b0;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_seq_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) wb ();

    wb_seq_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
        .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_v_i      (cmd_v),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_we_i     (cmd_we),
        .cmd_sel_i    (cmd_sel),
        .cmd_len_i    (cmd_len),
        .wdata_v_i    (wdata_v),
        .wdata_i      (wdata),
        .wdata_yumi_o (wdata_yumi),
        .rdata_v_o    (rdata_v),
        .rdata_o      (rdata),
        .rdata_last_o (rdata_last),
        .rdata_ready_i(rdata_ready),
        .err_o        (err),
        .wb           (wb.master)
    );

    // RAM slave: acks one cycle after strobe, never twice in a row; unwritten words read 0xDEAD0000|addr.
    logic [DW-1:0] mem     [0:16383];
    bit            written [0:16383];
    bit            ack_en = 1'b1;

    always @(posedge clk) begin
        if (!reset_n) begin
            wb.ack_i <= 1'b0;
            wb.dat_i <= '0;
        end else if (wb.cyc_o && wb.stb_o && !wb.ack_i && ack_en) begin
            wb.ack_i <= 1'b1;
            if (wb.we_o) begin
                mem[wb.adr_o[AW-1:2]]     <= wb.dat_o;
                written[wb.adr_o[AW-1:2]] <= 1'b1;
            end else begin
                wb.dat_i <= written[wb.adr_o[AW-1:2]] ? mem[wb.adr_o[AW-1:2]]
                                                      : (32'hDEAD_0000 | 32'(wb.adr_o));
            end
        end else begin
            wb.ack_i <= 1'b0;
        end
    end

    // Write-data source fed from a queue.
    logic [DW-1:0] wq[$];
    int            yumi_cnt = 0;

    initial begin
        bit pop;
        forever begin
            @(negedge clk);
            pop = wdata_yumi;
            @(posedge clk);
            #1;
            if (pop) begin
                void'(wq.pop_front());
                yumi_cnt++;
            end
            wdata_v = (wq.size() != 0);
            wdata   = (wq.size() != 0) ? wq[0] : '0;
        end
    end

    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] dat;
    } beat_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic          last;
    } rbeat_t;

    beat_t  bq[$];
    rbeat_t rq[$];
    int     err_cnt = 0;

    always @(negedge clk) begin
        if (wb.cyc_o && wb.stb_o && wb.ack_i)
            bq.push_back('{wb.adr_o, wb.we_o, wb.we_o ? wb.dat_o : wb.dat_i});
        if (rdata_v && rdata_ready)
            rq.push_back('{rdata, rdata_last});
        if (err)
            err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [AW-1:0] addr, input logic we, input logic [SW-1:0] sel,
                         input logic [LW-1:0] len);
        @(negedge clk);
        check("cmd_ready_before_issue", cmd_ready, 1'b1);
        cmd_addr = addr;
        cmd_we   = we;
        cmd_sel  = sel;
        cmd_len  = len;
        cmd_v    = 1'b1;
        @(posedge clk);
        #1;
        cmd_v = 1'b0;
    endtask

    // Counts consecutive cyc_o-high cycles after an accept, bounded.
    task automatic wait_idle(input string tag, output int cyc_cycles);
        bit done = 1'b0;
        cyc_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!wb.cyc_o) begin
                done = 1'b1;
                break;
            end
            cyc_cycles++;
        end
        check({tag, "_completes"}, done, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    n;
        int    y0;
        bit    ok;
        beat_t b;

        // Reset and idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_cyc", wb.cyc_o, 1'b0);
        check("rst_stb", wb.stb_o, 1'b0);
        check("rst_we", wb.we_o, 1'b0);
        check("rst_adr", wb.adr_o, 16'h0);
        check("rst_dat", wb.dat_o, 32'h0);
        check("rst_sel", wb.sel_o, 4'h0);
        check("rst_rdata", {rdata_v, rdata_last, err, wdata_yumi}, 4'b0000);
        check("rst_rdata_o", rdata, 32'h0);
        check("rst_cmd_ready", cmd_ready, 1'b1);

        // Four-beat write then read-back of the same range.
        for (int i = 0; i < 4; i++) wq.push_back(32'hA0 + 32'(i));
        issue(16'h0010, 1'b1, 4'hF, 8'd3);
        wait_idle("wr4", n);
        check("wr4_cyc_cycles", n, 12);
        check("wr4_beats", bq.size(), 4);
        for (int i = 0; i < 4 && i < bq.size(); i++) begin
            check($sformatf("wr4_adr%0d", i), bq[i].adr, 16'h0010 + 16'(4 * i));
            check($sformatf("wr4_dat%0d", i), {bq[i].we, bq[i].dat}, {1'b1, 32'hA0 + 32'(i)});
        end
        bq.delete();

        rdata_ready = 1'b1;
        issue(16'h0012, 1'b0, 4'hF, 8'd3);
        wait_idle("rd4", n);
        check("rd4_cyc_cycles", n, 12);
        check("rd4_beats", rq.size(), 4);
        for (int i = 0; i < 4 && i < rq.size(); i++) begin
            check($sformatf("rd4_dat%0d", i), rq[i].dat, 32'hA0 + 32'(i));
            check($sformatf("rd4_last%0d", i), rq[i].last, (i == 3));
        end
        for (int i = 0; i < 4 && i < bq.size(); i++)
            check($sformatf("rd4_adr%0d", i), bq[i].adr, 16'h0010 + 16'(4 * i));
        bq.delete();
        rq.delete();

        // Read with a stalled consumer.
        rdata_ready = 1'b0;
        issue(16'h0010, 1'b0, 4'hF, 8'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rdata_v) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("stall_rdata_v_seen", ok, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(rdata_v && rdata == 32'hA0 && !rdata_last && !wb.stb_o && wb.cyc_o)) ok = 1'b0;
        end
        check("stall_hold", ok, 1'b1);
        check("stall_rdata", rdata, 32'hA0);
        #1;
        rdata_ready = 1'b1;
        @(negedge clk);
        check("stall_restrobe", {wb.stb_o, wb.adr_o}, {1'b1, 16'h0014});
        wait_idle("stall", n);
        check("stall_second_beat", rq.size(), 1);
        if (rq.size() > 0) check("stall_second_data", {rq[0].last, rq[0].dat}, {1'b1, 32'hA1});
        bq.delete();
        rq.delete();

        // Address wrap at the top of the space.
        wq.push_back(32'h5A5A_0001);
        issue(16'hFFFC, 1'b1, 4'hF, 8'd0);
        wait_idle("wr1", n);
        check("wr1_cyc_cycles", n, 3);
        issue(16'hFFFC, 1'b0, 4'hF, 8'd1);
        wait_idle("wrap", n);
        check("wrap_cyc_cycles", n, 6);
        check("wrap_beats", bq.size(), 3);
        if (bq.size() == 3) begin
            check("wrap_adr0", bq[0].adr, 16'hFFFC);
            check("wrap_adr1", bq[1].adr, 16'hFFFC);
            check("wrap_adr2", bq[2].adr, 16'h0000);
        end
        check("wrap_rbeats", rq.size(), 2);
        if (rq.size() == 2) begin
            check("wrap_rd0", {rq[0].last, rq[0].dat}, {1'b0, 32'h5A5A_0001});
            check("wrap_rd1", {rq[1].last, rq[1].dat}, {1'b1, 32'hDEAD_0000});
        end
        bq.delete();
        rq.delete();

`ifdef WB_SEQ_MASTER_TIMEOUT_EN
        // Slave that never acks.
        ack_en = 1'b0;
        issue(16'h0020, 1'b0, 4'hF, 8'd1);
        wait_idle("tmo", n);
        check("tmo_cyc_cycles", n, TMO);
        @(negedge clk);
        check("tmo_err_pulses", err_cnt, 1);
        check("tmo_err_low", err, 1'b0);
        check("tmo_no_rdata", rq.size(), 0);
        ack_en = 1'b1;
        issue(16'h0020, 1'b0, 4'hF, 8'd0);
        wait_idle("post_tmo", n);
        check("post_tmo_cyc_cycles", n, 3);
        check("post_tmo_rbeats", rq.size(), 1);
        bq.delete();
        rq.delete();
`endif

        // Reset during the second beat of a four-beat write.
        y0 = yumi_cnt;
        for (int i = 0; i < 4; i++) wq.push_back(32'hB0 + 32'(i));
        issue(16'h0040, 1'b1, 4'hF, 8'd3);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (yumi_cnt - y0 == 2 && wb.stb_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_rst_reached_beat2", ok, 1'b1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_cyc_stb", {wb.cyc_o, wb.stb_o}, 2'b00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wb.cyc_o || wdata_yumi || rdata_v || err) ok = 1'b0;
        end
        check("mid_rst_quiet", ok, 1'b1);
        check("mid_rst_yumis", yumi_cnt - y0, 2);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_beat2_unwritten", written[16'h0044 >> 2], 1'b0);
        wq.delete();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
